// File: rtl/bexkat1_pkg.sv
// Shared types and helpers for the bexkat1 memory/write-back stage.
//   op_t       : request opcode carried by the execute stage
//   SZ_*       : access/write size codes, matching the register file encoding
//   wb_state_t : stage controller states
package bexkat1_pkg;

    typedef enum logic [1:0] {
        OpAlu   = 2'd0,
        OpLoad  = 2'd1,
        OpStore = 2'd2,
        OpNop   = 2'd3
    } op_t;

    localparam logic [1:0] SZ_NONE = 2'd0;
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;
    localparam logic [1:0] SZ_WORD = 2'd3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBus  = 2'd1,
        StWb   = 2'd2
    } wb_state_t;

    // Memory ops encode a word access as either SZ_NONE or SZ_WORD.
    function automatic logic [1:0] mem_size(input logic [1:0] size);
        return (size == SZ_NONE) ? SZ_WORD : size;
    endfunction

    function automatic logic misaligned(input logic [1:0] addr, input logic [1:0] size);
        case (size)
            SZ_HALF: return addr[0];
            SZ_WORD: return addr != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_lane_extract.sv
// Big-endian byte-lane helper: picks the addressed lane out of a bus word and
// zero-extends it, and reports the matching lane-select mask.
//   data  : bus word
//   addr  : byte offset within the word (0 = bits [31:24])
//   size  : SZ_BYTE / SZ_HALF / SZ_WORD (SZ_NONE treated as word)
//   value : zero-extended lane contents
//   sel   : byte lane selects
module load_lane_extract
    import bexkat1_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       addr,
    input  logic [1:0]       size,
    output logic [WIDTH-1:0] value,
    output logic [3:0]       sel
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = 8'h00;
        unique case (addr)
            2'd0: byte_lane = data[31:24];
            2'd1: byte_lane = data[23:16];
            2'd2: byte_lane = data[15:8];
            2'd3: byte_lane = data[7:0];
            default: byte_lane = 8'h00;
        endcase
        half_lane = addr[1] ? data[15:0] : data[31:16];
    end

    always_comb begin
        value = data;
        sel   = 4'b1111;
        case (size)
            SZ_BYTE: begin
                value = {{(WIDTH-8){1'b0}}, byte_lane};
                sel   = 4'b1000 >> addr;
            end
            SZ_HALF: begin
                value = {{(WIDTH-16){1'b0}}, half_lane};
                sel   = addr[1] ? 4'b0011 : 4'b1100;
            end
            default: begin
                value = data;
                sel   = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/mem_writeback.sv
// Final bexkat1 pipeline stage: forwards ALU results to the register file with
// one cycle of latency, runs single-beat bus cycles for loads/stores and carries
// the push/pop stack-pointer update so both register writes land together.
//   clk_i, rst_ni         : clock, synchronous active-low reset
//   in_*                  : request from execute (valid/ready handshake)
//   bus_*                 : Wishbone-style single-beat master
//   rf_write_*, rf_sp_*   : register file dest and SP write ports (size codes)
//   fault_o               : one-cycle pulse on bus error or misaligned access
module mem_writeback
    import bexkat1_pkg::*;
#(
    parameter int unsigned       WIDTH  = 32,
    parameter int unsigned       COUNTP = 4,
    parameter logic [COUNTP-1:0] SPREG  = 4'd15
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [1:0]        in_size,
    input  logic [WIDTH-1:0]  in_addr,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [COUNTP-1:0] in_dest,
    input  logic [WIDTH-1:0]  in_sp_data,
    input  logic [1:0]        in_sp_en,

    output logic              bus_cyc_o,
    output logic              bus_stb_o,
    output logic              bus_we_o,
    output logic [WIDTH-1:0]  bus_adr_o,
    output logic [WIDTH-1:0]  bus_dat_o,
    output logic [3:0]        bus_sel_o,
    input  logic [WIDTH-1:0]  bus_dat_i,
    input  logic              bus_ack_i,
    input  logic              bus_err_i,

    output logic [COUNTP-1:0] rf_write_addr,
    output logic [WIDTH-1:0]  rf_write_data,
    output logic [1:0]        rf_write_en,
    output logic [WIDTH-1:0]  rf_sp_data,
    output logic [1:0]        rf_sp_en,
    output logic              fault_o
);

    wb_state_t state_q, state_d;

    // Request fields held across the bus cycle.
    logic              is_load_q, is_load_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [COUNTP-1:0] dest_q, dest_d;
    logic [WIDTH-1:0]  sp_data_q, sp_data_d;
    logic [1:0]        sp_en_q, sp_en_d;

    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [WIDTH-1:0]  adr_q, adr_d;
    logic [WIDTH-1:0]  dat_q, dat_d;
    logic [3:0]        sel_q, sel_d;

    logic [COUNTP-1:0] rf_addr_q, rf_addr_d;
    logic [WIDTH-1:0]  rf_data_q, rf_data_d;
    logic [1:0]        rf_en_q, rf_en_d;
    logic [WIDTH-1:0]  rf_sp_data_q, rf_sp_data_d;
    logic [1:0]        rf_sp_en_q, rf_sp_en_d;
    logic              fault_q, fault_d;

    op_t               op;
    logic              accept;
    logic              is_mem;
    logic              dest_writes;
    logic              sp_conflict;
    logic [1:0]        req_size;
    logic [1:0]        req_sp_en;
    logic [WIDTH-1:0]  store_data;

    logic [1:0]        lane_addr;
    logic [1:0]        lane_size;
    logic [WIDTH-1:0]  lane_value;
    logic [3:0]        lane_sel;

    assign in_ready = (state_q != StBus);

    // Accepts only happen outside StBus and extraction only inside it, so one
    // lane helper serves both the request lane selects and the load data.
    assign lane_addr = (state_q == StBus) ? addr_lo_q : in_addr[1:0];
    assign lane_size = (state_q == StBus) ? size_q : req_size;

    load_lane_extract #(
        .WIDTH (WIDTH)
    ) u_lane (
        .data  (bus_dat_i),
        .addr  (lane_addr),
        .size  (lane_size),
        .value (lane_value),
        .sel   (lane_sel)
    );

    always_comb begin
        op          = op_t'(in_op);
        accept      = in_valid && in_ready;
        is_mem      = (op == OpLoad) || (op == OpStore);
        req_size    = is_mem ? mem_size(in_size) : in_size;
        // Only an op that really writes its dest can collide with the SP write.
        dest_writes = (op == OpLoad) || ((op == OpAlu) && (in_size != SZ_NONE));
        sp_conflict = dest_writes && (in_dest == SPREG) && (in_sp_en != SZ_NONE);
        req_sp_en   = sp_conflict ? SZ_NONE : in_sp_en;

        case (req_size)
            SZ_BYTE: store_data = {4{in_data[7:0]}};
            SZ_HALF: store_data = {2{in_data[15:0]}};
            default: store_data = in_data;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        is_load_d    = is_load_q;
        size_d       = size_q;
        addr_lo_d    = addr_lo_q;
        dest_d       = dest_q;
        sp_data_d    = sp_data_q;
        sp_en_d      = sp_en_q;
        cyc_d        = cyc_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        rf_addr_d    = rf_addr_q;
        rf_data_d    = rf_data_q;
        rf_sp_data_d = rf_sp_data_q;
        rf_en_d      = SZ_NONE;
        rf_sp_en_d   = SZ_NONE;
        fault_d      = 1'b0;

        unique case (state_q)
            StIdle, StWb: begin
                state_d = StIdle;
                if (accept) begin
                    if (!is_mem) begin
                        state_d      = StWb;
                        rf_addr_d    = in_dest;
                        rf_data_d    = in_data;
                        rf_en_d      = in_size;
                        rf_sp_data_d = in_sp_data;
                        rf_sp_en_d   = req_sp_en;
                    end else if (misaligned(in_addr[1:0], req_size)) begin
                        fault_d = 1'b1;
                    end else begin
                        state_d   = StBus;
                        is_load_d = (op == OpLoad);
                        size_d    = req_size;
                        addr_lo_d = in_addr[1:0];
                        dest_d    = in_dest;
                        sp_data_d = in_sp_data;
                        sp_en_d   = req_sp_en;
                        cyc_d     = 1'b1;
                        we_d      = (op == OpStore);
                        adr_d     = {in_addr[WIDTH-1:2], 2'b00};
                        dat_d     = store_data;
                        sel_d     = lane_sel;
                    end
                end
            end
            StBus: begin
                if (bus_ack_i) begin
                    state_d      = StWb;
                    cyc_d        = 1'b0;
                    we_d         = 1'b0;
                    sel_d        = 4'b0000;
                    rf_addr_d    = dest_q;
                    rf_sp_data_d = sp_data_q;
                    rf_sp_en_d   = sp_en_q;
                    if (is_load_q) begin
                        rf_data_d = lane_value;
                        rf_en_d   = size_q;
                    end
                end else if (bus_err_i) begin
                    state_d = StIdle;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = 4'b0000;
                    fault_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            is_load_q    <= 1'b0;
            size_q       <= SZ_NONE;
            addr_lo_q    <= 2'b00;
            dest_q       <= '0;
            sp_data_q    <= '0;
            sp_en_q      <= SZ_NONE;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= 4'b0000;
            rf_addr_q    <= '0;
            rf_data_q    <= '0;
            rf_en_q      <= SZ_NONE;
            rf_sp_data_q <= '0;
            rf_sp_en_q   <= SZ_NONE;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_load_q    <= is_load_d;
            size_q       <= size_d;
            addr_lo_q    <= addr_lo_d;
            dest_q       <= dest_d;
            sp_data_q    <= sp_data_d;
            sp_en_q      <= sp_en_d;
            cyc_q        <= cyc_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            rf_addr_q    <= rf_addr_d;
            rf_data_q    <= rf_data_d;
            rf_en_q      <= rf_en_d;
            rf_sp_data_q <= rf_sp_data_d;
            rf_sp_en_q   <= rf_sp_en_d;
            fault_q      <= fault_d;
        end
    end

    assign bus_cyc_o     = cyc_q;
    assign bus_stb_o     = cyc_q;
    assign bus_we_o      = we_q;
    assign bus_adr_o     = adr_q;
    assign bus_dat_o     = dat_q;
    assign bus_sel_o     = sel_q;
    assign rf_write_addr = rf_addr_q;
    assign rf_write_data = rf_data_q;
    assign rf_write_en   = rf_en_q;
    assign rf_sp_data    = rf_sp_data_q;
    assign rf_sp_en      = rf_sp_en_q;
    assign fault_o       = fault_q;

endmodule

// File: doc/mem_writeback.md
Name: mem_writeback

Overview:
- Final pipeline stage of the bexkat1 core. It sits between the execute stage and the register file write ports.
- ALU results are forwarded to the register file with one cycle of latency.
- Loads and stores run a single-beat Wishbone-style bus cycle. Load data is byte-lane extracted and zero-extended before write-back.
- The stack-pointer update from push/pop is carried alongside, so the register file sees its dual write (dest + SP) in the same cycle.

Parameters:
- WIDTH, 32, datapath and bus width (lane logic defined for 32 only).
- COUNTP, 4, register address bits.
- SPREG, 4'd15, stack pointer register index (used only for SP-conflict detection).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- in_valid  in  1  execute stage has an op.
- in_ready  out  1  this stage accepts an op this cycle.
- in_op  in  2  0=ALU, 1=LOAD, 2=STORE, 3=NOP (SP-only).
- in_size  in  2  0=no reg write (ALU/NOP) or word (LOAD/STORE); 1=byte; 2=half; 3=word.
- in_addr  in  WIDTH  effective address.
- in_data  in  WIDTH  ALU result or store data.
- in_dest  in  COUNTP  destination register.
- in_sp_data  in  WIDTH  new SP value.
- in_sp_en  in  2  SP write size code; 0 = no SP write.
- bus_cyc_o, bus_stb_o, bus_we_o  out  1 each  bus cycle, strobe, write enable.
- bus_adr_o  out  WIDTH  word address (in_addr with [1:0] cleared).
- bus_dat_o  out  WIDTH  store data.
- bus_sel_o  out  4  byte lane selects.
- bus_dat_i  in  WIDTH  read data.
- bus_ack_i, bus_err_i  in  1 each  bus termination.
- rf_write_addr  out  COUNTP  register file write address.
- rf_write_data  out  WIDTH  register file write data.
- rf_write_en  out  2  register file write size code.
- rf_sp_data  out  WIDTH  register file SP write data.
- rf_sp_en  out  2  register file SP write size code.
- fault_o  out  1  one-cycle pulse on bus error or misalignment.

Behaviour:
- Reset (rst_ni=0 at a clk_i edge): state=IDLE; all bus_* outputs 0; rf_write_en=0, rf_sp_en=0, rf_* data/addr 0; fault_o=0. A bus cycle in progress is abandoned; cyc/stb drop at that edge.
- State machine IDLE/BUS/WB. in_ready=1 in IDLE and WB, 0 in BUS.
- Accept occurs on in_valid & in_ready. All request fields are captured on accept.
- ALU/NOP accept:
  - Next cycle state=WB; rf_write_en=in_size, rf_write_addr=in_dest, rf_write_data=in_data; rf_sp_* from inputs.
  - Latency 1. Back-to-back ALU ops give throughput 1/cycle.
- LOAD/STORE accept, aligned:
  - Next cycle state=BUS with cyc=stb=1, we=(op==STORE).
  - bus_sel_o: byte = 4'b1000>>addr[1:0]; half = addr[1] ? 4'b0011 : 4'b1100; word = 4'b1111.
  - Byte ordering is big-endian: addr[1:0]=0 is bits [31:24].
  - Store data is replicated to all selected lanes: byte {4{d[7:0]}}, half {2{d[15:0]}}.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0. No bus cycle is issued. Next cycle fault_o=1, no rf writes (SP suppressed too), state=IDLE.
- BUS state: signals are held stable until ack or err. Multi-cycle wait is unbounded.
  - ack (ack has priority if err and ack coincide):
    - cyc/stb drop at the next edge; state=WB.
    - LOAD: rf_write_data = selected lane zero-extended, rf_write_en = size (0 is mapped to 3).
    - STORE: rf_write_en=0.
    - rf_sp_en is applied in both cases.
  - err: cyc/stb drop; fault_o pulses 1 cycle; no rf writes; state=IDLE.
- WB state:
  - rf_* outputs are valid for exactly one cycle.
  - A new accept in WB loads the next op. Otherwise state=IDLE and rf_write_en/rf_sp_en are cleared.
- SP conflict: if a LOAD/ALU has in_dest==SPREG and in_sp_en!=0, the dest write wins. rf_sp_en is forced to 0, so only one SP source reaches the register file.
- Write-enable codes are identical to the register file encoding; the register file applies its own masking on top.

Decomposition:
- Package bexkat1_pkg holds:
  - op_t enum (ALU/LOAD/STORE/NOP);
  - size codes (SZ_NONE/BYTE/HALF/WORD);
  - wb_state_t enum (IDLE/BUS/WB).
- One combinational sub-module, load_lane_extract (inputs: data, addr[1:0], size; output: zero-extended value). It is reused for the bus_sel_o computation.

Test Plan:
- Reset with outputs held, then ALU in_size=3, dest=2, data=32'h12345678 -> one cycle later rf_write_en=3, addr=2, data=32'h12345678 for exactly 1 cycle; 3 back-to-back ALU ops -> 3 consecutive WB cycles, in_ready stays 1.
- LOAD byte at addr=32'h1002, bus_dat_i=32'hAABBCCDD, ack after 3 waits -> bus_sel_o=4'b0010 held 4 cycles, then rf_write_data=32'h000000CC, rf_write_en=1.
- STORE half at addr=32'h2002, data=32'h0000BEEF with in_sp_en=3, sp_data=32'h7FFC -> bus_dat_o=32'hBEEFBEEF, sel=4'b0011, we=1; after ack rf_write_en=0, rf_sp_en=3, rf_sp_data=32'h7FFC.
- LOAD word at addr=32'h3001 -> no cyc/stb, fault_o pulse 1 cycle, rf_write_en=rf_sp_en=0; bus_err_i during a LOAD -> fault_o pulse, no write.
- Deassert rst_ni while in BUS -> at that edge cyc/stb=0, state IDLE; after release, an ALU op completes normally.
- Pop: LOAD dest=15, in_sp_en=3 -> rf_write_en=3 to reg 15, rf_sp_en=0.
